// File: rtl/line_clear_controller_if.sv
// ---------------------------------------------------------------------------
// line_clear_controller_if
//
// Groups the request/result signals of the line-clear controller.
//
// Signals:
//   start         request a line-clear pass on grid_in (one cycle)
//   new_game      clear the published grid and the cumulative line count
//   grid_in       locked grid, row r at bits [10r+9:10r], row 0 = top
//   grid_state    published (compacted) grid, same row mapping
//   busy          high while a pass is running
//   done          one-cycle pulse when a pass completes
//   lines_cleared rows removed by the last pass
//   total_lines   cumulative rows removed, saturating at 16'hFFFF
//
// Modports:
//   master  the requester (drives start/new_game/grid_in)
//   slave   the controller (drives the results)
// ---------------------------------------------------------------------------
interface line_clear_controller_if;
  logic         start;
  logic         new_game;
  logic [199:0] grid_in;
  logic [199:0] grid_state;
  logic         busy;
  logic         done;
  logic [4:0]   lines_cleared;
  logic [15:0]  total_lines;

  modport master (
    output start, new_game, grid_in,
    input  grid_state, busy, done, lines_cleared, total_lines
  );

  modport slave (
    input  start, new_game, grid_in,
    output grid_state, busy, done, lines_cleared, total_lines
  );
endinterface

// File: rtl/line_clear_controller.sv
// ---------------------------------------------------------------------------
// line_clear_controller
//
// Runs the line-clear pass on the 10x20 playfield after a piece locks.
// The locked grid is copied into a working register, scanned bottom-up, and
// each completely filled row is removed by moving every row above it down
// one row per cycle. Only once the whole pass is finished is the compacted
// grid published on grid_state, so the CPU never reads a half-shifted grid.
//
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset (aborts any pass in progress)
//   bus    line_clear_controller_if.slave: start/new_game/grid_in in,
//          grid_state/busy/done/lines_cleared/total_lines out
// ---------------------------------------------------------------------------
module line_clear_controller (
  input  logic                    clk,
  input  logic                    reset,
  line_clear_controller_if.slave  bus
);
  localparam int              COLS       = 10;
  localparam int              ROWS       = 20;
  localparam logic [COLS-1:0] FULL_ROW   = '1;
  localparam logic [4:0]      BOTTOM_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t                 state;
  state_t                 state_next;
  logic [COLS*ROWS-1:0]   work;
  logic [4:0]             row_ptr;
  logic [4:0]             shift_ptr;
  logic [4:0]             clear_cnt;
  logic                   row_full;
  logic [16:0]            total_sum;
  logic [15:0]            total_sat;

  assign row_full  = (work[int'(row_ptr)*COLS +: COLS] == FULL_ROW);

  // Cumulative count is added one bit wider so the carry can drive saturation.
  assign total_sum = {1'b0, bus.total_lines} + {12'd0, clear_cnt};
  assign total_sat = total_sum[16] ? 16'hFFFF : total_sum[15:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // new_game has priority over start in IDLE; other states ignore both.
  // After the top row has been refilled the FSM returns to SCAN on the same
  // row_ptr, because new content has just dropped into that row.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!bus.new_game && bus.start) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (row_full) begin
          state_next = SHIFT;
        end else if (row_ptr == 5'd0) begin
          state_next = DONE;
        end
      end
      SHIFT: begin
        if (shift_ptr == 5'd0) begin
          state_next = SCAN;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and registered outputs. done is a pulse, so it defaults low
  // every cycle and is only raised on the DONE exit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work              <= '0;
      row_ptr           <= '0;
      shift_ptr         <= '0;
      clear_cnt         <= '0;
      bus.grid_state    <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.lines_cleared <= '0;
      bus.total_lines   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.new_game) begin
            bus.grid_state    <= '0;
            bus.total_lines   <= '0;
            bus.lines_cleared <= '0;
          end else if (bus.start) begin
            work      <= bus.grid_in;
            row_ptr   <= BOTTOM_ROW;
            clear_cnt <= '0;
            bus.busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (row_full) begin
            shift_ptr <= row_ptr;
          end else if (row_ptr != 5'd0) begin
            row_ptr <= row_ptr - 5'd1;
          end
        end
        SHIFT: begin
          if (shift_ptr != 5'd0) begin
            work[int'(shift_ptr)*COLS +: COLS] <= work[(int'(shift_ptr)-1)*COLS +: COLS];
            shift_ptr <= shift_ptr - 5'd1;
          end else begin
            work[COLS-1:0] <= '0;
            clear_cnt      <= clear_cnt + 5'd1;
          end
        end
        DONE: begin
          bus.grid_state    <= work;
          bus.lines_cleared <= clear_cnt;
          bus.total_lines   <= total_sat;
          bus.done          <= 1'b1;
          bus.busy          <= 1'b0;
        end
        default: begin
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_line_clear_controller.sv
// ---------------------------------------------------------------------------
// tb_line_clear_controller
//
// Directed bench for line_clear_controller. Each pass pushes its
// hand-computed result (grid, lines, total, latency) into a scoreboard
// queue; a monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_line_clear_controller;
  logic clk;
  logic reset;

  line_clear_controller_if bus ();

  line_clear_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [199:0] grid;
    logic [4:0]   lines;
    logic [15:0]  total;
    int           lat;
    int           start_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cycles = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Busy-cycle accumulator sampled mid-cycle.
  always @(negedge clk) if (bus.busy === 1'b1) busy_cycles <= busy_cycles + 1;

  task automatic checkOutput(input string name, input logic [199:0] actual,
                             input logic [199:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [199:0] with_row(input logic [199:0] g, input int r,
                                            input logic [9:0] v);
    logic [199:0] t;
    t = g;
    t[r*10 +: 10] = v;
    return t;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("grid_state", bus.grid_state, e.grid);
          checkOutput("lines_cleared", 200'(bus.lines_cleared), 200'(e.lines));
          checkOutput("total_lines", 200'(bus.total_lines), 200'(e.total));
          checkOutput("latency", 200'(cyc - e.start_cyc), 200'(e.lat));
          checkOutput("busy_at_done", 200'(bus.busy), 200'd0);
        end
      end
    end
  end

  // Issues one pass (inputs driven 1 ns after a rising edge) and waits for
  // done. With disturb set, start and new_game are pulsed mid-pass along
  // with a different grid_in; all of it must be ignored.
  task automatic applyStimulus(input logic [199:0] grid, input logic [199:0] exp_grid,
                               input logic [4:0] exp_lines, input logic [15:0] exp_total,
                               input int lat, input bit disturb);
    exp_t e;
    bit   found;
    e.grid      = exp_grid;
    e.lines     = exp_lines;
    e.total     = exp_total;
    e.lat       = lat;
    e.start_cyc = cyc + 1;
    sb.push_back(e);
    bus.grid_in = grid;
    bus.start   = 1'b1;
    found = 1'b0;
    for (int i = 1; i <= 600; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) bus.start = 1'b0;
      if (disturb && i == 5) begin
        bus.start    = 1'b1;
        bus.new_game = 1'b1;
        bus.grid_in  = '1;
      end else if (disturb && i == 6) begin
        bus.start    = 1'b0;
        bus.new_game = 1'b0;
      end
      if (bus.done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout actual=no_done required=done within 600 cycles");
    end
  endtask

  initial begin
    logic [199:0] g_single, g_single_exp, g_tetris, g_tetris_exp;
    logic [199:0] g_mixed, g_mixed_exp, g_top, g_top_exp, g_ones;
    int           busy_before;
    int           done_seen;

    g_ones       = '1;
    g_single     = with_row(with_row('0, 19, 10'h3FF), 18, 10'h001);
    g_single_exp = with_row('0, 19, 10'h001);
    g_tetris     = '0;
    for (int r = 16; r <= 19; r++) g_tetris = with_row(g_tetris, r, 10'h3FF);
    g_tetris     = with_row(g_tetris, 15, 10'h2AA);
    g_tetris_exp = with_row('0, 19, 10'h2AA);
    g_mixed      = with_row(with_row(with_row(with_row(with_row('0,
                     19, 10'h001), 18, 10'h3FF), 17, 10'h0F0), 10, 10'h3FF), 9, 10'h155);
    g_mixed_exp  = with_row(with_row(with_row('0, 19, 10'h001), 18, 10'h0F0), 11, 10'h155);
    g_top        = with_row(with_row('0, 0, 10'h3FF), 5, 10'h00F);
    g_top_exp    = with_row('0, 5, 10'h00F);

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.new_game = 1'b0;
    bus.grid_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_grid_state", bus.grid_state, '0);
    checkOutput("rst_busy", 200'(bus.busy), 200'd0);
    checkOutput("rst_done", 200'(bus.done), 200'd0);
    checkOutput("rst_lines_cleared", 200'(bus.lines_cleared), 200'd0);
    checkOutput("rst_total_lines", 200'(bus.total_lines), 200'd0);

    $display("[TB] empty grid");
    busy_before = busy_cycles;
    applyStimulus('0, '0, 5'd0, 16'd0, 21, 1'b0);
    checkOutput("empty_busy_cycles", 200'(busy_cycles - busy_before), 200'd21);

    $display("[TB] single bottom row, tetris, full grid, mixed rows, top row");
    applyStimulus(g_single, g_single_exp, 5'd1, 16'd1, 42, 1'b0);
    applyStimulus(g_tetris, g_tetris_exp, 5'd4, 16'd5, 105, 1'b0);
    applyStimulus(g_ones, '0, 5'd20, 16'd25, 441, 1'b0);
    applyStimulus(g_mixed, g_mixed_exp, 5'd2, 16'd27, 54, 1'b0);
    applyStimulus(g_top, g_top_exp, 5'd1, 16'd28, 23, 1'b0);

    $display("[TB] start/new_game while busy");
    applyStimulus(g_single, g_single_exp, 5'd1, 16'd29, 42, 1'b1);

    $display("[TB] saturation");
    @(posedge clk);
    #1;
    force bus.total_lines = 16'hFFFE;
    @(posedge clk);
    #1;
    release bus.total_lines;
    applyStimulus(g_tetris, g_tetris_exp, 5'd4, 16'hFFFF, 105, 1'b0);

    $display("[TB] reset mid-pass");
    @(posedge clk);
    #1;
    bus.grid_in = g_ones;
    bus.start   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midrst_grid_state", bus.grid_state, '0);
    checkOutput("midrst_busy", 200'(bus.busy), 200'd0);
    checkOutput("midrst_done", 200'(bus.done), 200'd0);
    checkOutput("midrst_lines_cleared", 200'(bus.lines_cleared), 200'd0);
    checkOutput("midrst_total_lines", 200'(bus.total_lines), 200'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    checkOutput("midrst_no_done", 200'(done_seen), 200'd0);
    checkOutput("midrst_idle_busy", 200'(bus.busy), 200'd0);
    @(posedge clk);
    #1;

    $display("[TB] start and new_game together");
    applyStimulus(g_single, g_single_exp, 5'd1, 16'd1, 42, 1'b0);
    @(posedge clk);
    #1;
    bus.grid_in  = g_ones;
    bus.start    = 1'b1;
    bus.new_game = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.new_game = 1'b0;
    checkOutput("ng_busy", 200'(bus.busy), 200'd0);
    checkOutput("ng_grid_state", bus.grid_state, '0);
    checkOutput("ng_total_lines", 200'(bus.total_lines), 200'd0);
    checkOutput("ng_lines_cleared", 200'(bus.lines_cleared), 200'd0);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("ng_busy_later", 200'(bus.busy), 200'd0);
    checkOutput("sb_empty", 200'(sb.size()), 200'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/line_clear_controller.md
# line_clear_controller

Sequences the line-clear pass on the 10x20 Tetris playfield after a piece locks. It takes a snapshot of the locked grid, scans it bottom-up, and removes every completely filled row by shifting the rows above it down one row per cycle. It then publishes the compacted grid as `grid_state`, the 200-bit vector read row-by-row by the CPU grid interface. It also keeps per-pass and cumulative line counts for scoring.

## Interface
- `COLS`, 10, cells per row. Fixed; the CPU row read is 10 bits wide.
- `ROWS`, 20, rows in the playfield.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  single-cycle request to run a line-clear pass on `grid_in`.
- `new_game`  input  1  clears `grid_state` and `total_lines`.
- `grid_in`  input  200  locked grid. Row r occupies bits [10r+9:10r]. Row 0 is the top row and row 19 is the bottom row.
- `grid_state`  output  200  published grid, using the same row mapping as `grid_in`.
- `busy`  output  1  high while a pass is in progress.
- `done`  output  1  one-cycle pulse when a pass completes.
- `lines_cleared`  output  5  number of rows removed by the last pass (0..20).
- `total_lines`  output  16  cumulative rows cleared; saturates at 16'hFFFF.

## Operation
- Internal registers:
  - `work` [199:0]: working copy of the grid.
  - `row_ptr` [4:0]: row currently being scanned.
  - `shift_ptr` [4:0]: row currently being written during a shift.
  - A 5-bit clear counter.
- FSM states: IDLE, SCAN, SHIFT, DONE.
- **IDLE**
  - If `new_game` = 1: `grid_state` <= 0, `total_lines` <= 0, `lines_cleared` <= 0. Stay in IDLE.
  - Else if `start` = 1: `work` <= `grid_in`, `row_ptr` <= 19, clear counter <= 0, `busy` <= 1. Go to SCAN.
  - If `start` and `new_game` are both high, `new_game` wins and `start` is dropped.
- **SCAN** (one row per cycle): the row is full when `work` row[`row_ptr`] == 10'h3FF.
  - If the row is full: `shift_ptr` <= `row_ptr`, go to SHIFT.
  - Else if `row_ptr` == 0: go to DONE.
  - Else: `row_ptr` <= `row_ptr` - 1.
- **SHIFT** (one row per cycle):
  - If `shift_ptr` != 0: row[`shift_ptr`] <= row[`shift_ptr`-1], then `shift_ptr` <= `shift_ptr` - 1.
  - If `shift_ptr` == 0: row[0] <= 0, clear counter +1, go to SCAN with `row_ptr` unchanged. The same row is rescanned because new content has dropped into it.
- **DONE** (1 cycle), updated on the exit edge:
  - `grid_state` <= `work`, `lines_cleared` <= clear counter.
  - `total_lines` <= min(`total_lines` + counter, 16'hFFFF), computed 17 bits wide and then saturated.
  - `done` <= 1, `busy` <= 0. Go to IDLE.
- `start` and `new_game` received while `busy` = 1 are ignored and not queued.
- `grid_state` changes only on the DONE exit edge or on `new_game`. The CPU therefore never sees a partially shifted grid.
- Reset values:
  - `grid_state` = 0, `busy` = 0, `done` = 0, `lines_cleared` = 0, `total_lines` = 0.
  - FSM = IDLE, `work` = 0, pointers = 0.
- Reset during a pass aborts it immediately. No `done` pulse is produced and no partial grid is published.

## Timing
- All outputs are registered.
- `busy` rises on the edge that samples `start`.
- `done` is high for exactly the one cycle following the DONE exit edge. `busy` falls on that same edge.
- Latency in cycles, from the `start` sampling edge to the edge that raises `done`:
  - Base: 21 (20 SCAN cycles plus 1 DONE cycle).
  - Each row cleared while `row_ptr` = r adds r+2 cycles (r+1 SHIFT cycles plus 1 rescan).
- A clear at row 0 adds 2 cycles. The worst case, a full grid, is 21 + 20*21 = 441 cycles.
- `start` may be asserted again in the cycle that `done` is high. It is accepted, because the FSM is in IDLE.

## Test plan
- **Empty grid:** `grid_in` = 0, pulse `start`.
  - `done` 21 cycles after start; `grid_state` = 0; `lines_cleared` = 0; `busy` high for exactly 21 cycles.
- **Single bottom row:** row 19 = 3FF, row 18 = 001, all other rows 0.
  - `done` at cycle 42; row 19 = 001 and all other rows 0; `lines_cleared` = 1; `total_lines` = 1.
- **Tetris:** rows 16..19 = 3FF, row 15 = 2AA.
  - `done` at cycle 105; row 19 = 2AA and all other rows 0; `lines_cleared` = 4.
- **Full grid:** `grid_in` = all ones.
  - `done` at cycle 441; `grid_state` = 0; `lines_cleared` = 20.
- **Saturation and new_game:** preload `total_lines` to FFFE via repeated passes or a forced value, then clear 4 rows.
  - `total_lines` = FFFF.
  - Pulse `start` and `new_game` together in IDLE: `grid_state` = 0, `total_lines` = 0, `busy` stays 0.
- **Mid-pass disturbances:** assert `reset` in cycle 10 of a clearing pass.
  - All outputs go to 0 at once, with no `done` pulse.
  - Separately, a `start` pulse while `busy` = 1 is ignored: latency and result are unchanged.
